// File: rtl/comp_if_ctrl.sv
// -----------------------------------------------------------------------------
// comp_if_ctrl -- sequencer for a hardware "if / then / else" construct.
//
// A job latches three operands and broadcasts them to three sub-units. The
// predicate unit runs first. Its non-zero result selects the "then" unit and a
// zero result selects the "else" unit. The selected unit then runs and its
// result is returned on RES.
//
// Each sub-unit uses a start/ready handshake. The controller pulses *_ST for
// one cycle. It then waits for the unit's RD to drop (job taken) and to rise
// again (result valid).
//
// Optional feature (macro COMP_IF_TIMEOUT_EN):
//   This enables a watchdog on every wait phase. When a phase lasts TIMEOUT
//   cycles, the job is aborted with RES = all ones and ERR = 1. Without the
//   macro, waits are unbounded and ERR is tied to 0.
//
// Parameters:
//   WIDTH   - datapath width of operands and results
//   TIMEOUT - watchdog limit in cycles per wait phase (macro builds only)
//
// Ports:
//   CLK, RST          - clock, asynchronous active-low reset
//   ST, RD            - outer start request / ready-done
//   IN1..IN3          - operands, latched on job accept
//   OP1..OP3          - latched operands driven to all sub-units
//   RES, BR, ERR      - branch result, branch taken (1 = then), abort flag
//   P_ST/T_ST/E_ST    - start pulses to predicate / then / else units
//   P_RD/T_RD/E_RD    - ready from predicate / then / else units
//   P_RES/T_RES/E_RES - results from predicate / then / else units
// -----------------------------------------------------------------------------
module comp_if_ctrl #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ST,
  output logic             RD,
  input  logic [WIDTH-1:0] IN1,
  input  logic [WIDTH-1:0] IN2,
  input  logic [WIDTH-1:0] IN3,
  output logic [WIDTH-1:0] RES,
  output logic [WIDTH-1:0] OP1,
  output logic [WIDTH-1:0] OP2,
  output logic [WIDTH-1:0] OP3,
  output logic             P_ST,
  output logic             T_ST,
  output logic             E_ST,
  input  logic             P_RD,
  input  logic             T_RD,
  input  logic             E_RD,
  input  logic [WIDTH-1:0] P_RES,
  input  logic [WIDTH-1:0] T_RES,
  input  logic [WIDTH-1:0] E_RES,
  output logic             BR,
  output logic             ERR
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] P_ISSUE = 3'd1;
  localparam logic [2:0] P_WLO   = 3'd2;
  localparam logic [2:0] P_WHI   = 3'd3;
  localparam logic [2:0] B_ISSUE = 3'd4;
  localparam logic [2:0] B_WLO   = 3'd5;
  localparam logic [2:0] B_WHI   = 3'd6;

  logic [2:0]       state, next_state;
  logic             br_sel;   // branch chosen by the predicate of the current job
  logic             accept;
  logic             in_wait;
  logic             timeout;
  logic             sel_rd;
  logic [WIDTH-1:0] sel_res;

  assign accept  = (state == IDLE) && ST;
  assign in_wait = (state == P_WLO) || (state == P_WHI) ||
                   (state == B_WLO) || (state == B_WHI);
  assign sel_rd  = br_sel ? T_RD  : E_RD;
  assign sel_res = br_sel ? T_RES : E_RES;

  // Handshake outputs decode straight from state. Reset or abort forces IDLE,
  // so no start pulse can leak out after either event.
  assign RD   = (state == IDLE);
  assign P_ST = (state == P_ISSUE);
  assign T_ST = (state == B_ISSUE) &&  br_sel;
  assign E_ST = (state == B_ISSUE) && !br_sel;

`ifdef COMP_IF_TIMEOUT_EN
  localparam int             CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;
  logic          err_q;

  // The counter holds the number of wait cycles already spent in this phase.
  // The abort fires on the edge that ends the TIMEOUT-th wait cycle.
  assign timeout = in_wait && (cnt == CNT_LAST);
  assign ERR     = err_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if ((state == P_ISSUE) || (state == B_ISSUE)) cnt <= '0;
      else if (in_wait)                             cnt <= cnt + 1'b1;

      if (accept)       err_q <= 1'b0;
      else if (timeout) err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign ERR     = 1'b0;
`endif

  // NOTE: next_state gets a default before the case, so no path can leave it
  // unassigned. A combinational block that misses an assignment on some path
  // infers a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (ST)     next_state = P_ISSUE;
      P_ISSUE:             next_state = P_WLO;
      P_WLO:   if (!P_RD)  next_state = P_WHI;
      P_WHI:   if (P_RD)   next_state = B_ISSUE;
      B_ISSUE:             next_state = B_WLO;
      B_WLO:   if (!sel_rd) next_state = B_WHI;
      B_WHI:   if (sel_rd) next_state = IDLE;
      default:             next_state = IDLE;
    endcase
    if (timeout) next_state = IDLE;
  end

  // NOTE: all state is updated with non-blocking assignments, so every
  // register samples pre-edge values regardless of block order. The design
  // holds only flops and no memories, so every register has a defined reset
  // value.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= next_state;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      OP1    <= '0;
      OP2    <= '0;
      OP3    <= '0;
      br_sel <= 1'b0;
      BR     <= 1'b0;
      RES    <= '0;
    end else begin
      if (accept) begin
        OP1 <= IN1;
        OP2 <= IN2;
        OP3 <= IN3;
      end

      // br_sel steers the current job. BR is published only at completion,
      // so BR keeps its last value until the next job finishes.
      if ((state == P_WHI) && P_RD && !timeout) br_sel <= |P_RES;

      if (timeout) begin
        RES <= '1;
      end else if ((state == B_WHI) && sel_rd) begin
        RES <= sel_res;
        BR  <= br_sel;
      end
    end
  end

endmodule

// File: tb/tb_comp_if_ctrl.sv
// -----------------------------------------------------------------------------
// tb_comp_if_ctrl -- self-checking bench for comp_if_ctrl.
//
// Three mock sub-units drop RD for 'lat' cycles after they sample their start
// pulse. A scoreboard queue holds the expected result, branch, latency and
// operand for each job. Define COMP_IF_TIMEOUT_EN to exercise the watchdog
// with TIMEOUT = 8.
// -----------------------------------------------------------------------------
module tb_comp_if_ctrl;

  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 8;
  localparam int BOUND   = 1000;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             br;
    int               lat;
    logic [WIDTH-1:0] op1;
  } exp_t;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             ST  = 1'b0;
  logic             RD;
  logic [WIDTH-1:0] IN1 = '0, IN2 = '0, IN3 = '0;
  logic [WIDTH-1:0] RES, OP1, OP2, OP3;
  logic             P_ST, T_ST, E_ST;
  logic             P_RD, T_RD, E_RD;
  logic [WIDTH-1:0] P_RES, T_RES, E_RES;
  logic             BR, ERR;

  logic             clk_en  = 1'b0;
  logic             p_stuck = 1'b0;
  int               lat     = 3;
  logic [WIDTH-1:0] pres = '0, tres = '0, eres = '0;

  int   assertions = 0;
  int   failures   = 0;
  int   n_p = 0, n_t = 0, n_e = 0, n_overlap = 0;
  exp_t sb[$];

  comp_if_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .ST(ST), .RD(RD),
    .IN1(IN1), .IN2(IN2), .IN3(IN3), .RES(RES),
    .OP1(OP1), .OP2(OP2), .OP3(OP3),
    .P_ST(P_ST), .T_ST(T_ST), .E_ST(E_ST),
    .P_RD(P_RD), .T_RD(T_RD), .E_RD(E_RD),
    .P_RES(P_RES), .T_RES(T_RES), .E_RES(E_RES),
    .BR(BR), .ERR(ERR)
  );

  always #5 if (clk_en) CLK = ~CLK;

  // Mock sub-units: RD is low for exactly 'lat' cycles after a sampled start.
  logic p_rd_m, t_rd_m, e_rd_m;
  int   p_left, t_left, e_left;

  always @(posedge CLK or negedge RST)
    if (!RST) begin p_rd_m <= 1'b1; p_left <= 0; end
    else if (P_ST) begin p_rd_m <= 1'b0; p_left <= lat - 1; end
    else if (!p_rd_m) begin if (p_left == 0) p_rd_m <= 1'b1; else p_left <= p_left - 1; end

  always @(posedge CLK or negedge RST)
    if (!RST) begin t_rd_m <= 1'b1; t_left <= 0; end
    else if (T_ST) begin t_rd_m <= 1'b0; t_left <= lat - 1; end
    else if (!t_rd_m) begin if (t_left == 0) t_rd_m <= 1'b1; else t_left <= t_left - 1; end

  always @(posedge CLK or negedge RST)
    if (!RST) begin e_rd_m <= 1'b1; e_left <= 0; end
    else if (E_ST) begin e_rd_m <= 1'b0; e_left <= lat - 1; end
    else if (!e_rd_m) begin if (e_left == 0) e_rd_m <= 1'b1; else e_left <= e_left - 1; end

  assign P_RD  = p_rd_m & ~p_stuck;
  assign T_RD  = t_rd_m;
  assign E_RD  = e_rd_m;
  assign P_RES = pres;
  assign T_RES = tres;
  assign E_RES = eres;

  // Start-pulse monitor, sampled on the active edge (pre-edge values).
  always @(posedge CLK) begin
    n_p       <= n_p + int'(P_ST);
    n_t       <= n_t + int'(T_ST);
    n_e       <= n_e + int'(E_ST);
    n_overlap <= n_overlap + ((int'(P_ST) + int'(T_ST) + int'(E_ST) > 1) ? 1 : 0);
  end

  // Drive one job's inputs and push the behavioural expectation.
  task automatic push_job(input logic [WIDTH-1:0] i1, pr, tr, er, input int l);
    exp_t x;
    IN1 = i1; IN2 = i1 + 16'd1; IN3 = i1 + 16'd2;
    pres = pr; tres = tr; eres = er; lat = l;
    x.br  = (pr != '0);
    x.res = x.br ? tr : er;
    x.lat = 2 * (l + 2);
    x.op1 = i1;
    sb.push_back(x);
  endtask

  // Count edges until RD is seen high; bounded so a stuck DUT cannot hang.
  task automatic wait_rd(output int edges);
    edges = 0;
    while (RD !== 1'b1 && edges < BOUND) begin
      @(negedge CLK);
      edges++;
    end
  endtask

  task automatic run_job(input string tag, input logic [WIDTH-1:0] i1, pr, tr, er, input int l);
    int   p0, t0, e0, edges;
    exp_t x;
    p0 = n_p; t0 = n_t; e0 = n_e;
    @(negedge CLK);
    push_job(i1, pr, tr, er, l);
    ST = 1'b1;
    @(negedge CLK);
    ST = 1'b0;
    assertions++; if (RD !== 1'b0) begin failures++; $display("FAIL %s_accept: RD got %b want 0", tag, RD); end
    assertions++; if (ERR !== 1'b0) begin failures++; $display("FAIL %s_err_clear: ERR got %b want 0", tag, ERR); end
    wait_rd(edges);
    x = sb.pop_front();
    assertions++; if (edges != x.lat) begin failures++; $display("FAIL %s_latency: got %0d want %0d", tag, edges, x.lat); end
    assertions++; if (RES !== x.res) begin failures++; $display("FAIL %s_res: got %h want %h", tag, RES, x.res); end
    assertions++; if (BR !== x.br) begin failures++; $display("FAIL %s_br: got %b want %b", tag, BR, x.br); end
    assertions++; if (OP1 !== x.op1) begin failures++; $display("FAIL %s_op1: got %h want %h", tag, OP1, x.op1); end
    assertions++; if (n_p - p0 != 1) begin failures++; $display("FAIL %s_p_pulses: got %0d want 1", tag, n_p - p0); end
    assertions++; if (n_t - t0 != (x.br ? 1 : 0)) begin failures++; $display("FAIL %s_t_pulses: got %0d want %0d", tag, n_t - t0, x.br ? 1 : 0); end
    assertions++; if (n_e - e0 != (x.br ? 0 : 1)) begin failures++; $display("FAIL %s_e_pulses: got %0d want %0d", tag, n_e - e0, x.br ? 0 : 1); end
  endtask

  task automatic test_reset;
    RST = 1'b0;
    #1;
    assertions++; if (RD !== 1'b1) begin failures++; $display("FAIL reset_rd: got %b want 1", RD); end
    assertions++; if (RES !== '0) begin failures++; $display("FAIL reset_res: got %h want 0", RES); end
    assertions++; if ({P_ST, T_ST, E_ST} !== 3'b000) begin failures++; $display("FAIL reset_st: got %b want 000", {P_ST, T_ST, E_ST}); end
    assertions++; if ({OP1, OP2, OP3} !== '0) begin failures++; $display("FAIL reset_op: got %h want 0", {OP1, OP2, OP3}); end
    assertions++; if ({BR, ERR} !== 2'b00) begin failures++; $display("FAIL reset_br_err: got %b want 00", {BR, ERR}); end
    clk_en = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_then_path;
    run_job("then_l3", 16'd7, 16'd5, 16'h1234, 16'h0BAD, 3);
    run_job("then_l5", 16'h0100, 16'h8000, 16'h4321, 16'h0BAD, 5);
  endtask

  task automatic test_else_path;
    run_job("else_l3", 16'h0009, 16'h0000, 16'h0BAD, 16'h00AB, 3);
    run_job("else_l1", 16'h000A, 16'h0000, 16'h0BAD, 16'h00CD, 1);
  endtask

  task automatic test_protocol_ignore;
    int   p0, t0, e0, edges;
    exp_t x;
    p0 = n_p; t0 = n_t; e0 = n_e;
    @(negedge CLK);
    push_job(16'h0011, 16'h0001, 16'h0022, 16'h0BAD, 3);
    ST = 1'b1;
    @(negedge CLK);
    ST = 1'b0;
    @(negedge CLK);
    IN1 = 16'hDEAD;
    ST  = 1'b1;
    @(negedge CLK);
    ST = 1'b0;
    assertions++; if (OP1 !== 16'h0011) begin failures++; $display("FAIL ignore_op1_stable: got %h want 0011", OP1); end
    wait_rd(edges);
    x = sb.pop_front();
    assertions++; if (edges + 2 != x.lat) begin failures++; $display("FAIL ignore_latency: got %0d want %0d", edges + 2, x.lat); end
    assertions++; if (RES !== x.res) begin failures++; $display("FAIL ignore_res: got %h want %h", RES, x.res); end
    repeat (3) @(negedge CLK);
    assertions++; if (RD !== 1'b1) begin failures++; $display("FAIL ignore_rd_idle: got %b want 1", RD); end
    assertions++; if ({n_p - p0, n_t - t0, n_e - e0} != {32'd1, 32'd1, 32'd0}) begin failures++; $display("FAIL ignore_pulses: got p%0d t%0d e%0d want p1 t1 e0", n_p - p0, n_t - t0, n_e - e0); end
  endtask

  task automatic test_back_to_back;
    int   p0, t0, e0, edges;
    exp_t x;
    p0 = n_p; t0 = n_t; e0 = n_e;
    @(negedge CLK);
    push_job(16'h0101, 16'h0003, 16'h0AAA, 16'h0555, 2);
    ST = 1'b1;
    @(negedge CLK);
    wait_rd(edges);
    x = sb.pop_front();
    assertions++; if (edges != x.lat) begin failures++; $display("FAIL b2b_first_latency: got %0d want %0d", edges, x.lat); end
    assertions++; if (RES !== x.res) begin failures++; $display("FAIL b2b_first_res: got %h want %h", RES, x.res); end
    push_job(16'h0202, 16'h0000, 16'h0BAD, 16'h0BBB, 4);
    @(negedge CLK);
    ST = 1'b0;
    assertions++; if (RD !== 1'b0) begin failures++; $display("FAIL b2b_second_accept: RD got %b want 0", RD); end
    assertions++; if (OP1 !== 16'h0202) begin failures++; $display("FAIL b2b_second_op1: got %h want 0202", OP1); end
    wait_rd(edges);
    x = sb.pop_front();
    assertions++; if (edges != x.lat) begin failures++; $display("FAIL b2b_second_latency: got %0d want %0d", edges, x.lat); end
    assertions++; if (RES !== x.res || BR !== x.br) begin failures++; $display("FAIL b2b_second_result: got %h/%b want %h/%b", RES, BR, x.res, x.br); end
    assertions++; if ({n_p - p0, n_t - t0, n_e - e0} != {32'd2, 32'd1, 32'd1}) begin failures++; $display("FAIL b2b_pulses: got p%0d t%0d e%0d want p2 t1 e1", n_p - p0, n_t - t0, n_e - e0); end
  endtask

  task automatic test_reset_mid_job;
    int   p0, t0, e0;
    exp_t x;
    @(negedge CLK);
    push_job(16'h0033, 16'h0001, 16'h0044, 16'h0BAD, 3);
    ST = 1'b1;
    @(negedge CLK);
    ST = 1'b0;
    repeat (6) @(negedge CLK);   // now in B_WLO
    x = sb.pop_back();           // job is abandoned
    #1 RST = 1'b0;
    #1;
    assertions++; if (RD !== 1'b1) begin failures++; $display("FAIL midrst_rd: got %b want 1", RD); end
    assertions++; if (RES !== '0) begin failures++; $display("FAIL midrst_res: got %h want 0", RES); end
    assertions++; if (OP1 !== '0) begin failures++; $display("FAIL midrst_op1: got %h want 0", OP1); end
    p0 = n_p; t0 = n_t; e0 = n_e;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    assertions++; if ({n_p - p0, n_t - t0, n_e - e0} != {32'd0, 32'd0, 32'd0}) begin failures++; $display("FAIL midrst_no_pulse: got p%0d t%0d e%0d want 0 0 0", n_p - p0, n_t - t0, n_e - e0); end
    run_job("after_rst", 16'h0055, 16'h0000, 16'h0BAD, 16'h0066, 3);
  endtask

`ifdef COMP_IF_TIMEOUT_EN
  task automatic test_timeout;
    int   p0, t0, e0, edges;
    exp_t x;
    p0 = n_p; t0 = n_t; e0 = n_e;
    p_stuck = 1'b1;
    @(negedge CLK);
    push_job(16'h0077, 16'h0001, 16'h0088, 16'h0099, 3);
    x = sb.pop_back();
    x.res = '1;
    x.lat = TIMEOUT + 1;   // one issue cycle plus TIMEOUT wait cycles
    sb.push_back(x);
    ST = 1'b1;
    @(negedge CLK);
    ST = 1'b0;
    wait_rd(edges);
    x = sb.pop_front();
    assertions++; if (edges != x.lat) begin failures++; $display("FAIL timeout_latency: got %0d want %0d", edges, x.lat); end
    assertions++; if (RES !== x.res) begin failures++; $display("FAIL timeout_res: got %h want %h", RES, x.res); end
    assertions++; if (ERR !== 1'b1) begin failures++; $display("FAIL timeout_err: got %b want 1", ERR); end
    p_stuck = 1'b0;
    repeat (4) @(negedge CLK);
    assertions++; if ({n_p - p0, n_t - t0, n_e - e0} != {32'd1, 32'd0, 32'd0}) begin failures++; $display("FAIL timeout_pulses: got p%0d t%0d e%0d want p1 t0 e0", n_p - p0, n_t - t0, n_e - e0); end
    assertions++; if (ERR !== 1'b1) begin failures++; $display("FAIL timeout_err_hold: got %b want 1", ERR); end
    run_job("after_to", 16'h0078, 16'h0002, 16'h0123, 16'h0BAD, 2);
  endtask
`else
  task automatic test_no_timeout;
    int   t0, edges;
    exp_t x;
    t0 = n_t;
    p_stuck = 1'b1;
    @(negedge CLK);
    push_job(16'h0079, 16'h0002, 16'h0066, 16'h0BAD, 3);
    ST = 1'b1;
    @(negedge CLK);
    ST = 1'b0;
    repeat (300) @(negedge CLK);
    assertions++; if (RD !== 1'b0 || ERR !== 1'b0) begin failures++; $display("FAIL nowd_waiting: RD/ERR got %b/%b want 0/0", RD, ERR); end
    assertions++; if (n_t != t0) begin failures++; $display("FAIL nowd_no_branch: got %0d want %0d", n_t, t0); end
    p_stuck = 1'b0;
    wait_rd(edges);
    x = sb.pop_front();
    // Resume: one edge to see P_RD high, then the branch phase takes L+2 edges.
    assertions++; if (edges != lat + 3) begin failures++; $display("FAIL nowd_resume_latency: got %0d want %0d", edges, lat + 3); end
    assertions++; if (RES !== x.res) begin failures++; $display("FAIL nowd_res: got %h want %h", RES, x.res); end
  endtask
`endif

  task automatic test_exclusive;
    assertions++; if (n_overlap != 0) begin failures++; $display("FAIL start_exclusive: got %0d overlapping cycles want 0", n_overlap); end
    assertions++; if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_drained: got %0d entries want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_then_path();
    test_else_path();
    test_protocol_ignore();
    test_back_to_back();
    test_reset_mid_job();
`ifdef COMP_IF_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
